// File: rtl/feature_packer_if.sv
// rtl/feature_packer_if.sv - raw feature beat input and packed frame output handshakes
interface feature_packer_if #(
    parameter int NUM_FEAT = 11,
    parameter int FEAT_W   = 4,
    parameter int IN_W     = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [IN_W-1:0]            in_data;
    logic                       in_sof;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_FEAT*FEAT_W-1:0] out;
    logic                       frame_err;

    modport master (
        output in_valid, in_data, in_sof, out_ready,
        input  in_ready, out_valid, out, frame_err
    );

    modport slave (
        input  in_valid, in_data, in_sof, out_ready,
        output in_ready, out_valid, out, frame_err
    );
endinterface

// File: rtl/feature_packer.sv
// rtl/feature_packer.sv - packs NUM_FEAT raw samples into one frame; FEATURE_PACKER_CLAMP_EN saturates instead of truncating
module feature_packer #(
    parameter int NUM_FEAT = 11,
    parameter int FEAT_W   = 4,
    parameter int IN_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    feature_packer_if.slave  bus
);
    localparam int CNT_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_FEAT - 1);
    localparam logic [IN_W-1:0]  SAT  = IN_W'((1 << FEAT_W) - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                     state, state_nxt;
    logic [CNT_W-1:0]           cnt, cnt_nxt, idx;
    logic [NUM_FEAT*FEAT_W-1:0] frame;
    logic                       frame_err_q, err_nxt;
    logic                       accept, consume;
    logic [FEAT_W-1:0]          feat;

`ifdef FEATURE_PACKER_CLAMP_EN
    assign feat = (bus.in_data > SAT) ? {FEAT_W{1'b1}} : bus.in_data[FEAT_W-1:0];
`else
    logic unused_sat;
    assign unused_sat = ^{SAT, bus.in_data};
    assign feat = bus.in_data[FEAT_W-1:0];
`endif

    assign bus.in_ready  = (state == FILL) || bus.out_ready;
    assign bus.out_valid = (state == HOLD);
    assign bus.out       = frame;
    assign bus.frame_err = frame_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    // A beat taken while a held frame is consumed becomes slot 0 of the next frame.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        accept    = bus.in_valid && bus.in_ready;
        consume   = (state == HOLD) && bus.out_ready;
        idx       = bus.in_sof ? '0 : cnt;
        if (consume) state_nxt = FILL;
        if (accept) begin
            err_nxt = bus.in_sof && (cnt != '0) && (state == FILL);
            if (idx == LAST) begin
                cnt_nxt   = '0;
                state_nxt = HOLD;
            end else begin
                cnt_nxt = idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            frame       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            frame_err_q <= err_nxt;
            if (accept) begin
                for (int k = 0; k < NUM_FEAT; k++) begin
                    if (idx == CNT_W'(k)) frame[k*FEAT_W +: FEAT_W] <= feat;
                end
            end
        end
    end
endmodule

// File: tb/tb_feature_packer.sv
// tb/tb_feature_packer.sv - self-checking bench for feature_packer against a slot-array reference model
module tb_feature_packer;
    localparam int NF = 11;
    localparam int FW = 4;
    localparam int IW = 8;
    localparam int OW = NF * FW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    feature_packer_if #(.NUM_FEAT(NF), .FEAT_W(FW), .IN_W(IW)) bus ();
    feature_packer #(.NUM_FEAT(NF), .FEAT_W(FW), .IN_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [FW-1:0] m_slot [NF];
    int  m_cnt;
    bit  m_hold, m_err;
    bit  exp_rdy, obs_rdy;

    function automatic logic [FW-1:0] feat_of(input logic [IW-1:0] d);
`ifdef FEATURE_PACKER_CLAMP_EN
        if (int'(d) > (2**FW - 1)) return FW'(2**FW - 1);
        return FW'(d);
`else
        return FW'(int'(d) % (2**FW));
`endif
    endfunction

    function automatic logic [OW-1:0] m_out();
        logic [OW-1:0] r = '0;
        for (int k = 0; k < NF; k++) r[k*FW +: FW] = m_slot[k];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NF; k++) m_slot[k] = '0;
        m_cnt = 0; m_hold = 1'b0; m_err = 1'b0;
    endtask

    // Drives one clock of stimulus and advances the reference model by the handshake rules.
    task automatic cycle(input bit v, input bit sof, input logic [IW-1:0] d, input bit ordy);
        bit acc, cons;
        int idx;
        bus.in_valid = v; bus.in_sof = sof; bus.in_data = d; bus.out_ready = ordy;
        #2;
        obs_rdy = bus.in_ready;
        exp_rdy = !m_hold || ordy;
        acc  = v && exp_rdy;
        cons = m_hold && ordy;
        @(posedge clk); #1;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_err = 1'b0;
        if (cons) m_hold = 1'b0;
        if (acc) begin
            idx = sof ? 0 : m_cnt;
            if (sof && m_cnt != 0) m_err = 1'b1;
            m_slot[idx] = feat_of(d);
            if (idx == NF - 1) begin
                m_cnt = 0; m_hold = 1'b1;
            end else begin
                m_cnt = idx + 1;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.out !== '0) begin errors++; $display("FAIL rst_out got %h want 0", bus.out); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err got %0b want 0", bus.frame_err); end
        cycle(1'b0, 1'b0, '0, 1'b0);
        checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", obs_rdy); end
    endtask

    task automatic test_fill_hold();
        do_reset();
        for (int k = 0; k < NF; k++) begin
            cycle(1'b1, k == 0, IW'(k), 1'b0);
            checks++;
            if (bus.out_valid !== (k == NF - 1)) begin
                errors++; $display("FAIL fill_out_valid beat %0d got %0b want %0b", k, bus.out_valid, k == NF - 1);
            end
        end
        checks++; if (bus.out !== 44'hA9876543210) begin errors++; $display("FAIL fill_out got %h want A9876543210", bus.out); end
        cycle(1'b1, 1'b0, 8'd5, 1'b0);
        checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL hold_in_ready got %0b want 0", obs_rdy); end
    endtask

    task automatic test_hold_consume();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'($urandom), IW'($urandom), 1'b0);
            checks++; if (bus.out !== 44'hA9876543210) begin errors++; $display("FAIL hold_stable cyc %0d got %h want A9876543210", i, bus.out); end
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc %0d got %0b want 1", i, bus.out_valid); end
            checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL hold_ready cyc %0d got %0b want 0", i, obs_rdy); end
        end
        cycle(1'b1, 1'b1, 8'd7, 1'b1);
        checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL consume_ready got %0b want 1", obs_rdy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL consume_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.out[3:0] !== 4'd7) begin errors++; $display("FAIL consume_slot0 got %0d want 7", bus.out[3:0]); end
        for (int k = 1; k < NF; k++) begin
            cycle(1'b1, 1'b0, IW'($urandom), 1'b0);
            checks++;
            if (bus.out_valid !== (k == NF - 1)) begin
                errors++; $display("FAIL next_frame_valid beat %0d got %0b want %0b", k, bus.out_valid, k == NF - 1);
            end
        end
        checks++; if (bus.out !== m_out()) begin errors++; $display("FAIL next_frame_out got %h want %h", bus.out, m_out()); end
        checks++; if (bus.out[3:0] !== 4'd7) begin errors++; $display("FAIL next_frame_slot0 got %0d want 7", bus.out[3:0]); end
    endtask

    task automatic test_frame_err();
        int pulses = 0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, k == 0, IW'($urandom), 1'b0);
            pulses += int'(bus.frame_err);
        end
        cycle(1'b1, 1'b1, 8'd3, 1'b0);
        checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL err_pulse got %0b want 1", bus.frame_err); end
        pulses += int'(bus.frame_err);
        for (int k = 1; k < NF; k++) begin
            cycle(1'b1, 1'b0, IW'($urandom), 1'b0);
            pulses += int'(bus.frame_err);
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL err_pulse_count got %0d want 1", pulses); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL err_frame_valid got %0b want 1", bus.out_valid); end
        checks++; if (bus.out[3:0] !== 4'd3) begin errors++; $display("FAIL err_slot0 got %0d want 3", bus.out[3:0]); end
        checks++; if (bus.out !== m_out()) begin errors++; $display("FAIL err_frame_out got %h want %h", bus.out, m_out()); end
    endtask

    task automatic test_clamp();
        logic [FW-1:0] want;
`ifdef FEATURE_PACKER_CLAMP_EN
        want = 4'd15;
`else
        want = 4'd8;
`endif
        do_reset();
        for (int k = 0; k < NF; k++) cycle(1'b1, k == 0, (k == 2) ? 8'd200 : IW'(k), 1'b0);
        checks++; if (bus.out[11:8] !== want) begin errors++; $display("FAIL clamp_slot2 got %0d want %0d", bus.out[11:8], want); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 6; k++) cycle(1'b1, k == 0, IW'($urandom), 1'b0);
        rst_n = 1'b0;
        cycle(1'b1, 1'b0, 8'd9, 1'b0);
        rst_n = 1'b1;
        checks++; if (bus.out !== '0) begin errors++; $display("FAIL midrst_out got %h want 0", bus.out); end
        for (int k = 0; k < NF; k++) begin
            cycle(1'b1, 1'b0, 8'd1, 1'b0);
            checks++;
            if (bus.out_valid !== (k == NF - 1)) begin
                errors++; $display("FAIL midrst_valid beat %0d got %0b want %0b", k, bus.out_valid, k == NF - 1);
            end
        end
        checks++; if (bus.out !== 44'h11111111111) begin errors++; $display("FAIL midrst_out_full got %h want 11111111111", bus.out); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int last = -1;
        bit prev = 1'b0;
        do_reset();
        for (int c = 0; c < 3 * NF + 1; c++) begin
            cycle(1'b1, 1'b0, IW'($urandom), 1'b1);
            if (bus.out_valid === 1'b1) begin
                pulses++;
                checks++; if (prev) begin errors++; $display("FAIL b2b_width cyc %0d got 2+ want 1", c); end
                checks++; if (bus.out !== m_out()) begin errors++; $display("FAIL b2b_out cyc %0d got %h want %h", c, bus.out, m_out()); end
                if (last >= 0) begin
                    checks++; if (c - last != NF) begin errors++; $display("FAIL b2b_gap got %0d want %0d", c - last, NF); end
                end
                last = c;
            end
            prev = (bus.out_valid === 1'b1);
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulses got %0d want 3", pulses); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            cycle(($urandom % 4) != 0, ($urandom % 8) == 0, IW'($urandom), ($urandom % 3) == 0);
            checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", c, obs_rdy, exp_rdy); end
            checks++; if (bus.out_valid !== m_hold) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", c, bus.out_valid, m_hold); end
            checks++; if (bus.frame_err !== m_err) begin errors++; $display("FAIL rnd_err cyc %0d got %0b want %0b", c, bus.frame_err, m_err); end
            checks++; if (bus.out !== m_out()) begin errors++; $display("FAIL rnd_out cyc %0d got %h want %h", c, bus.out, m_out()); end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        model_reset();
        test_reset();
        test_fill_hold();
        test_hold_consume();
        test_frame_err();
        test_clamp();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/feature_packer.md
FEATURE_PACKER -- requirements
Module: feature_packer

Interface
REQ-001 Parameter NUM_FEAT, default 11: number of features per frame.
REQ-002 Parameter FEAT_W, default 4: packed width of each feature.
REQ-003 Parameter IN_W, default 8: raw unsigned sample width on the input stream.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  raw feature beat present.
REQ-007 in_ready  output  1  block accepts the beat this cycle.
REQ-008 in_data  input  IN_W  raw unsigned feature sample.
REQ-009 in_sof  input  1  qualifies a beat as feature 0 of a new frame.
REQ-010 out_valid  output  1  packed frame available.
REQ-011 out_ready  input  1  downstream consumes the frame this cycle.
REQ-012 out  output  NUM_FEAT*FEAT_W  packed frame; feature k at bits [FEAT_W*k+FEAT_W-1 : FEAT_W*k], so feature 0 is the LSB nibble (44 bits by default).
REQ-013 frame_err  output  1  one-cycle pulse: frame restarted by in_sof before completion.

Function
REQ-014 Two states: FILL (collecting) and HOLD (frame complete, awaiting consumer).
REQ-015 A beat is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-016 FILL: in_ready=1, out_valid=0; each accepted beat writes slot cnt, then cnt increments.
REQ-017 Accepted beat with in_sof=1 writes slot 0 and sets cnt=1, regardless of the prior cnt.
REQ-018 in_sof=1 on an accepted beat while cnt is nonzero in FILL: frame_err=1 on the next cycle; previously written slots are not cleared.
REQ-019 in_sof=0 with cnt=0: beat is accepted as feature 0 (SOF optional for alignment).
REQ-020 Beat written to slot NUM_FEAT-1: cnt returns to 0, state goes to HOLD, out_valid=1 on the next cycle (latency 1 clock from the last accept).
REQ-021 HOLD: out_valid=1; out is stable and unchanged until consumed; in_ready=out_ready.
REQ-022 HOLD with out_ready=1: frame consumed, out_valid=0 next cycle, state goes to FILL; a beat accepted in the same cycle becomes slot 0 of the next frame (cnt=1 next); no bubble required.
REQ-023 HOLD with out_ready=0: no beats accepted; in_sof is ignored.
REQ-024 Slots not yet rewritten keep their values from the previous frame; out changes only via slot writes.
REQ-025 cnt width is clog2(NUM_FEAT); cnt never exceeds NUM_FEAT-1.

Reset
REQ-026 rst_n=0 on a rising edge: state=FILL, cnt=0, out=0, out_valid=0, frame_err=0; in_ready=1 from the first cycle after reset is released.
REQ-027 Reset mid-frame or in HOLD discards the partial or held frame; no out_valid pulse is produced.

Configuration
REQ-028 Macro FEATURE_PACKER_CLAMP_EN defined: slot value = min(in_data, 2^FEAT_W-1), e.g. 8'd200 gives 4'd15.
REQ-029 Macro FEATURE_PACKER_CLAMP_EN undefined: slot value = in_data[FEAT_W-1:0] (truncation), e.g. 8'd200 gives 4'd8.

Verification
REQ-030 After reset, 11 beats with in_data=k (k=0..10), in_sof on the first beat, out_ready=0 -> out_valid=1 one cycle after the 11th accept; out=44'hA9876543210; in_ready=0 while held.
REQ-031 Hold 5 cycles with out_ready=0, then out_ready=1 together with in_valid=1, in_sof=1, in_data=7 -> out unchanged during the hold; out_valid=0 next cycle; cnt=1; slot 0 = 7.
REQ-032 4 beats, then a beat with in_sof=1 and in_data=3 -> frame_err pulses exactly once; next 10 beats complete the frame with slot 0 = 3.
REQ-033 in_data=200 in slot 2 -> out[11:8]=15 with FEATURE_PACKER_CLAMP_EN defined, =8 without.
REQ-034 rst_n=0 after 6 beats, then 11 fresh beats of value 1 -> out_valid only after the 11th fresh beat; out=44'h11111111111.
REQ-035 Continuous in_valid=1 and out_ready=1 for 3 frames -> exactly 3 out_valid pulses, each 1 cycle, 11 accepts apart.
